dense_activate_pipe: RTL and testbench

// - Elastic pipeline register between the dense and activate stages; replaces the fixed single-slot delay bundle.
// - Carries the full stage bundle: act/dense/cost type, w, y, x, layer/row index, is_update, label, backprop_cost.
// - Uses a valid/ready handshake and a DEPTH-entry in-order buffer, so upstream and downstream can stall independently.
// - Provides synchronous flush and an occupancy count for the sequencer.

---
 rtl/dense_pipe_pkg.sv | 29 ++
 rtl/dense_activate_pipe_if.sv | 51 +++++
 rtl/pipe_fifo.sv | 58 +++++
 rtl/dense_activate_pipe.sv | 63 ++++++
 tb/tb_dense_activate_pipe.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dense_pipe_pkg.sv
// Shared widths and the dense->activate stage bundle type.
// The bundle is stored in the buffer as one packed word.
package dense_pipe_pkg;
    localparam int SIZE            = 3;
    localparam int DATA_SIZE       = 16;
    localparam int COST_TYPE_SIZE  = 8;
    localparam int DENSE_TYPE_SIZE = 4;
    localparam int ACT_TYPE_SIZE   = 4;
    localparam int VEC_W           = DATA_SIZE * SIZE;
    localparam int IDX_W           = 32;

    typedef struct packed {
        logic [ACT_TYPE_SIZE-1:0]   act_type;
        logic [DENSE_TYPE_SIZE-1:0] dense_type;
        logic [COST_TYPE_SIZE-1:0]  cost_type;
        logic [VEC_W-1:0]           w;
        logic [VEC_W-1:0]           y;
        logic [VEC_W-1:0]           x;
        logic [VEC_W-1:0]           label;
        logic [IDX_W-1:0]           w_layer_index;
        logic [IDX_W-1:0]           w_row_index;
        logic                       is_update;
        logic                       backprop_cost;
    } dense_act_bundle_t;

    function automatic int bundle_width();
        return $bits(dense_act_bundle_t);
    endfunction
endpackage

// File: rtl/dense_activate_pipe_if.sv
// Upstream bundle, downstream head copy, flush and occupancy between the
// dense stage, the pipe and the activate stage.
interface dense_activate_pipe_if #(parameter int DEPTH = 2) ();
    import dense_pipe_pkg::*;

    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [ACT_TYPE_SIZE-1:0]   act_type;
    logic [DENSE_TYPE_SIZE-1:0] dense_type;
    logic [COST_TYPE_SIZE-1:0]  cost_type;
    logic [VEC_W-1:0]           w;
    logic [VEC_W-1:0]           y;
    logic [VEC_W-1:0]           x;
    logic [VEC_W-1:0]           label;
    logic [IDX_W-1:0]           w_layer_index;
    logic [IDX_W-1:0]           w_row_index;
    logic                       is_update;
    logic                       backprop_cost;

    logic                       out_valid;
    logic                       out_ready;
    logic [ACT_TYPE_SIZE-1:0]   act_type_out;
    logic [DENSE_TYPE_SIZE-1:0] dense_type_out;
    logic [COST_TYPE_SIZE-1:0]  cost_type_out;
    logic [VEC_W-1:0]           w_out;
    logic [VEC_W-1:0]           y_out;
    logic [VEC_W-1:0]           x_out;
    logic [VEC_W-1:0]           label_out;
    logic [IDX_W-1:0]           w_layer_index_out;
    logic [IDX_W-1:0]           w_row_index_out;
    logic                       is_update_out;
    logic                       backprop_cost_out;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output flush, in_valid, act_type, dense_type, cost_type, w, y, x, label,
               w_layer_index, w_row_index, is_update, backprop_cost, out_ready,
        input  in_ready, out_valid, act_type_out, dense_type_out, cost_type_out,
               w_out, y_out, x_out, label_out, w_layer_index_out, w_row_index_out,
               is_update_out, backprop_cost_out, count
    );

    modport slave (
        input  flush, in_valid, act_type, dense_type, cost_type, w, y, x, label,
               w_layer_index, w_row_index, is_update, backprop_cost, out_ready,
        output in_ready, out_valid, act_type_out, dense_type_out, cost_type_out,
               w_out, y_out, x_out, label_out, w_layer_index_out, w_row_index_out,
               is_update_out, backprop_cost_out, count
    );
endinterface

// File: rtl/pipe_fifo.sv
// In-order DEPTH-entry buffer with valid/ready on both sides and sync flush.
// Ready depends only on occupancy, so there is no path from out_ready to in_ready.
module pipe_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Wrap on DEPTH-1 explicitly so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            // Storage is intentionally left as-is; only bookkeeping clears.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/dense_activate_pipe.sv
// Elastic register between dense and activate: packs the stage bundle into
// one word, buffers it in pipe_fifo and presents the head entry field by field.
module dense_activate_pipe
    import dense_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dense_activate_pipe_if.slave  bus
);
    localparam int BW = bundle_width();

    dense_act_bundle_t in_b;
    dense_act_bundle_t head;
    logic [$clog2(DEPTH+1)-1:0] count;

    assign in_b.act_type      = bus.act_type;
    assign in_b.dense_type    = bus.dense_type;
    assign in_b.cost_type     = bus.cost_type;
    assign in_b.w             = bus.w;
    assign in_b.y             = bus.y;
    assign in_b.x             = bus.x;
    assign in_b.label         = bus.label;
    assign in_b.w_layer_index = bus.w_layer_index;
    assign in_b.w_row_index   = bus.w_row_index;
    assign in_b.is_update     = bus.is_update;
    assign in_b.backprop_cost = bus.backprop_cost;

    pipe_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_b),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head),
        .count     (count)
    );

    assign bus.count             = count;
    assign bus.act_type_out      = head.act_type;
    assign bus.dense_type_out    = head.dense_type;
    assign bus.cost_type_out     = head.cost_type;
    assign bus.w_out             = head.w;
    assign bus.y_out             = head.y;
    assign bus.x_out             = head.x;
    assign bus.label_out         = head.label;
    assign bus.w_layer_index_out = head.w_layer_index;
    assign bus.w_row_index_out   = head.w_row_index;
    assign bus.is_update_out     = head.is_update;
    assign bus.backprop_cost_out = head.backprop_cost;

    // Flush moves rd_ptr to 0, so stability only holds on a plain stall.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready && !bus.flush) |=> $stable(head));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= DEPTH);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (!bus.in_ready && !bus.flush) |=> (count <= $past(count)));
endmodule

// File: tb/tb_dense_activate_pipe.sv
// Randomized and directed checks of dense_activate_pipe at DEPTH=2 and 3
// against a queue model of an in-order elastic buffer.
module tb_dense_activate_pipe;
    import dense_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   sel = 2;
    int   depth = 2;
    logic flush_d = 1'b0, valid_d = 1'b0, oready_d = 1'b0;
    dense_act_bundle_t drv = '0;

    int checks = 0;
    int failures = 0;
    dense_act_bundle_t q[$];

    dense_activate_pipe_if #(.DEPTH(2)) b2 ();
    dense_activate_pipe_if #(.DEPTH(3)) b3 ();

    dense_activate_pipe #(.DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    dense_activate_pipe #(.DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b2.flush = flush_d;            assign b3.flush = flush_d;
    assign b2.in_valid = valid_d & (sel == 2);
    assign b3.in_valid = valid_d & (sel == 3);
    assign b2.out_ready = oready_d;       assign b3.out_ready = oready_d;
    assign b2.act_type = drv.act_type;    assign b3.act_type = drv.act_type;
    assign b2.dense_type = drv.dense_type; assign b3.dense_type = drv.dense_type;
    assign b2.cost_type = drv.cost_type;  assign b3.cost_type = drv.cost_type;
    assign b2.w = drv.w;                  assign b3.w = drv.w;
    assign b2.y = drv.y;                  assign b3.y = drv.y;
    assign b2.x = drv.x;                  assign b3.x = drv.x;
    assign b2.label = drv.label;          assign b3.label = drv.label;
    assign b2.w_layer_index = drv.w_layer_index; assign b3.w_layer_index = drv.w_layer_index;
    assign b2.w_row_index = drv.w_row_index;     assign b3.w_row_index = drv.w_row_index;
    assign b2.is_update = drv.is_update;         assign b3.is_update = drv.is_update;
    assign b2.backprop_cost = drv.backprop_cost; assign b3.backprop_cost = drv.backprop_cost;

    logic o_valid, o_ready;
    int   o_count;
    dense_act_bundle_t o_head;

    always_comb begin
        o_valid = b2.out_valid;
        o_ready = b2.in_ready;
        o_count = int'(b2.count);
        o_head  = '{b2.act_type_out, b2.dense_type_out, b2.cost_type_out, b2.w_out,
                    b2.y_out, b2.x_out, b2.label_out, b2.w_layer_index_out,
                    b2.w_row_index_out, b2.is_update_out, b2.backprop_cost_out};
        if (sel == 3) begin
            o_valid = b3.out_valid;
            o_ready = b3.in_ready;
            o_count = int'(b3.count);
            o_head  = '{b3.act_type_out, b3.dense_type_out, b3.cost_type_out, b3.w_out,
                        b3.y_out, b3.x_out, b3.label_out, b3.w_layer_index_out,
                        b3.w_row_index_out, b3.is_update_out, b3.backprop_cost_out};
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s (depth %0d): got %0h expected %0h", tag, depth, obs, exp);
        end
    endtask

    task automatic rand_bundle();
        drv.act_type      = ACT_TYPE_SIZE'($urandom);
        drv.dense_type    = DENSE_TYPE_SIZE'($urandom);
        drv.cost_type     = COST_TYPE_SIZE'($urandom);
        drv.w             = VEC_W'({$urandom, $urandom});
        drv.y             = VEC_W'({$urandom, $urandom});
        drv.x             = VEC_W'({$urandom, $urandom});
        drv.label         = VEC_W'({$urandom, $urandom});
        drv.w_layer_index = $urandom;
        drv.w_row_index   = $urandom;
        drv.is_update     = 1'($urandom);
        drv.backprop_cost = 1'($urandom);
    endtask

    // One clock with the currently driven inputs; model updated from the
    // buffer rules, then all visible state compared.
    task automatic cycle();
        bit mr, push, pop;
        mr   = (q.size() != depth);
        chk("in_ready_pre", 512'(o_ready), 512'(mr));
        push = valid_d && mr && !flush_d;
        pop  = (q.size() != 0) && oready_d && !flush_d;
        @(posedge clk); #1;
        if (flush_d) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(drv);
        end
        chk("count", 512'(o_count), 512'(q.size()));
        chk("out_valid", 512'(o_valid), 512'(q.size() != 0));
        chk("in_ready", 512'(o_ready), 512'(q.size() != depth));
        if (q.size() != 0) chk("head", 512'(o_head), 512'(q[0]));
    endtask

    task automatic switch_to(input int d);
        flush_d = 1'b1; valid_d = 1'b0;
        cycle();
        flush_d = 1'b0;
        sel = d; depth = d;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 512'(o_valid), 512'(0));
        chk("rst_count", 512'(o_count), 512'(0));
        chk("rst_in_ready", 512'(o_ready), 512'(1));
        chk("rst_w_out", 512'(o_head.w), 512'(0));
        chk("rst_act_type", 512'(o_head.act_type), 512'(0));
        rst_n = 1'b1;

        // Single pass
        drv = '0; drv.w = 48'h0003_0002_0001; valid_d = 1'b1; oready_d = 1'b1;
        cycle();
        chk("single_w", 512'(o_head.w), 512'(48'h0003_0002_0001));
        chk("single_valid", 512'(o_valid), 512'(1));
        valid_d = 1'b0;
        cycle();
        chk("single_drained", 512'(o_count), 512'(0));

        // Fill and stall
        oready_d = 1'b0; valid_d = 1'b1;
        rand_bundle(); drv.w_row_index = 5; cycle();
        rand_bundle(); drv.w_row_index = 6; cycle();
        chk("full_count", 512'(o_count), 512'(2));
        chk("full_in_ready", 512'(o_ready), 512'(0));
        rand_bundle(); drv.w_row_index = 7; cycle();
        valid_d = 1'b0; oready_d = 1'b1;
        chk("stall_first", 512'(o_head.w_row_index), 512'(5));
        cycle();
        chk("stall_second", 512'(o_head.w_row_index), 512'(6));
        cycle();
        chk("stall_empty", 512'(o_valid), 512'(0));

        // Push and pop together at count 1
        oready_d = 1'b0; valid_d = 1'b1; rand_bundle(); cycle();
        oready_d = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_bundle(); cycle(); end
        chk("pp_count", 512'(o_count), 512'(1));
        valid_d = 1'b0; cycle();

        // Flush with two entries and a bundle offered in the flush cycle
        oready_d = 1'b0; valid_d = 1'b1;
        rand_bundle(); cycle(); rand_bundle(); cycle();
        flush_d = 1'b1; rand_bundle(); drv.w_row_index = 99; cycle();
        chk("flush_count", 512'(o_count), 512'(0));
        chk("flush_valid", 512'(o_valid), 512'(0));
        flush_d = 1'b0; valid_d = 1'b0; oready_d = 1'b1;
        repeat (3) cycle();

        // Wrap at DEPTH=3 over 10 pushes
        switch_to(3);
        for (int i = 0; i < 10; i++) begin
            valid_d = 1'b1; oready_d = (i > 0); rand_bundle(); drv.w_row_index = 100 + i;
            cycle();
        end
        chk("wrap_last", 512'(o_head.w_row_index), 512'(109));
        valid_d = 1'b0; cycle();

        // Random traffic on both depths
        for (int d = 2; d <= 3; d++) begin
            switch_to(d);
            for (int i = 0; i < 300; i++) begin
                valid_d  = ($urandom_range(0, 3) != 0);
                oready_d = ($urandom_range(0, 2) != 0);
                flush_d  = ($urandom_range(0, 39) == 0);
                rand_bundle();
                cycle();
            end
            flush_d = 1'b0;
        end

        // Async reset between edges mid-burst
        switch_to(2);
        oready_d = 1'b0; valid_d = 1'b1;
        rand_bundle(); cycle(); rand_bundle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", 512'(o_valid), 512'(0));
        chk("areset_count", 512'(o_count), 512'(0));
        chk("areset_w_out", 512'(o_head.w), 512'(0));
        q.delete();
        valid_d = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        valid_d = 1'b1; oready_d = 1'b1; rand_bundle(); drv.w_row_index = 42;
        cycle();
        chk("post_reset_row", 512'(o_head.w_row_index), 512'(42));
        valid_d = 1'b0; cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
